// File: rtl/bpsk_feeder_pkg.sv
// Shared types and constants for the BPSK symbol feeder and its upstream helpers.
package bpsk_feeder_pkg;

    localparam int BYTE_W            = 8;
    localparam int DEF_SYMBOL_CYCLES = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
    } byte_ent_t;

endpackage

// File: rtl/axis_byte_hold.sv
// One-entry AXI4-Stream holding buffer. TREADY is registered and reports an empty buffer.
module axis_byte_hold
    import bpsk_feeder_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BYTE_W-1:0] s_tdata_i,
    input  logic              s_tvalid_i,
    input  logic              s_tlast_i,
    output logic              s_tready_o,
    input  logic              pop_i,
    output logic              buf_valid_o,
    output byte_ent_t         buf_o
);

    logic      buf_valid_q, buf_valid_d;
    byte_ent_t buf_q, buf_d;
    logic      tready_q;
    logic      push;

    assign push = s_tvalid_i && tready_q;

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path can infer a latch.
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (pop_i) begin
            buf_valid_d = 1'b0;
        end
        if (push) begin
            buf_valid_d = 1'b1;
            buf_d       = '{data: s_tdata_i, last: s_tlast_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            // NOTE: TREADY has its own flop so it reads 0 during reset rather than !buf_valid.
            tready_q    <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            tready_q    <= !buf_valid_d;
        end
    end

    assign s_tready_o  = tready_q;
    assign buf_valid_o = buf_valid_q;
    assign buf_o       = buf_q;

endmodule

// File: rtl/bpsk_symbol_feeder.sv
// Serialises AXI4-Stream bytes MSB-first into BPSK symbols of SYMBOL_CYCLES clocks and
// drives the shared gen_en / phase_ctrl inputs of the phase-generator lanes.
module bpsk_symbol_feeder
    import bpsk_feeder_pkg::*;
#(
    parameter int SYMBOL_CYCLES = DEF_SYMBOL_CYCLES,
    parameter bit DIFF_ENC      = 1'b0
) (
    input  logic              S_AXIS_ACLK,
    input  logic              S_AXIS_ARESET,
    input  logic [BYTE_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TVALID,
    input  logic              S_AXIS_TLAST,
    output logic              S_AXIS_TREADY,
    output logic              gen_en,
    output logic              phase_ctrl,
    output logic              sym_strobe,
    output logic              frame_done,
    output logic              underrun
);

    localparam int              CNT_W    = $clog2(SYMBOL_CYCLES);
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYMBOL_CYCLES - 1);

    state_e            state_q;
    logic [BYTE_W-1:0] shift_q;
    logic              last_q;
    logic [2:0]        bit_cnt_q;
    logic [CNT_W-1:0]  sym_cnt_q;
    logic              gen_en_q, phase_q, strobe_q, done_q, under_q;

    logic      buf_valid;
    byte_ent_t buf_ent;
    logic      sym_first, sym_last, at_byte_end, load;

    assign sym_first   = (sym_cnt_q == '0);
    assign sym_last    = (sym_cnt_q == SYM_LAST);
    assign at_byte_end = (state_q == SEND) && sym_last && (bit_cnt_q == 3'd7);
    // The buffer is drained either to start a frame or to continue one with no gap.
    assign load        = buf_valid && ((state_q == IDLE) || at_byte_end);

    axis_byte_hold u_hold (
        .clk_i       (S_AXIS_ACLK),
        .rst_i       (S_AXIS_ARESET),
        .s_tdata_i   (S_AXIS_TDATA),
        .s_tvalid_i  (S_AXIS_TVALID),
        .s_tlast_i   (S_AXIS_TLAST),
        .s_tready_o  (S_AXIS_TREADY),
        .pop_i       (load),
        .buf_valid_o (buf_valid),
        .buf_o       (buf_ent)
    );

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            last_q    <= 1'b0;
            bit_cnt_q <= '0;
            sym_cnt_q <= '0;
            gen_en_q  <= 1'b0;
            phase_q   <= 1'b0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            under_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    gen_en_q <= 1'b0;
                    phase_q  <= 1'b0;
                    if (load) begin
                        shift_q   <= buf_ent.data;
                        last_q    <= buf_ent.last;
                        bit_cnt_q <= '0;
                        sym_cnt_q <= '0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    gen_en_q <= 1'b1;
                    if (sym_first) begin
                        strobe_q <= 1'b1;
                        // Differential mode toggles the running phase on a 1 bit.
                        phase_q  <= shift_q[BYTE_W-1] ^ (DIFF_ENC & phase_q);
                    end
                    if (!sym_last) begin
                        sym_cnt_q <= sym_cnt_q + CNT_W'(1);
                    end else begin
                        sym_cnt_q <= '0;
                        if (!at_byte_end) begin
                            shift_q   <= shift_q << 1;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else if (load) begin
                            shift_q   <= buf_ent.data;
                            last_q    <= buf_ent.last;
                            bit_cnt_q <= '0;
                        end else begin
                            done_q    <= last_q;
                            under_q   <= !last_q;
                            bit_cnt_q <= '0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gen_en     = gen_en_q;
    assign phase_ctrl = phase_q;
    assign sym_strobe = strobe_q;
    assign frame_done = done_q;
    assign underrun   = under_q;

endmodule

// File: tb/tb_bpsk_symbol_feeder.sv
// Scoreboard bench for bpsk_symbol_feeder: three configurations (SC=4 abs, SC=4 diff, SC=2 abs),
// one driven at a time, with a frame-level reference model feeding per-cycle expectations.
module tb_bpsk_symbol_feeder;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]      tdata [NDUT];
    logic [NDUT-1:0] tvalid, tlast, tready, gen_en, phase, strobe, done, under;

    bpsk_symbol_feeder #(.SYMBOL_CYCLES(4), .DIFF_ENC(1'b0)) u_abs (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TDATA(tdata[0]),
        .S_AXIS_TVALID(tvalid[0]), .S_AXIS_TLAST(tlast[0]), .S_AXIS_TREADY(tready[0]),
        .gen_en(gen_en[0]), .phase_ctrl(phase[0]), .sym_strobe(strobe[0]),
        .frame_done(done[0]), .underrun(under[0]));

    bpsk_symbol_feeder #(.SYMBOL_CYCLES(4), .DIFF_ENC(1'b1)) u_diff (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TDATA(tdata[1]),
        .S_AXIS_TVALID(tvalid[1]), .S_AXIS_TLAST(tlast[1]), .S_AXIS_TREADY(tready[1]),
        .gen_en(gen_en[1]), .phase_ctrl(phase[1]), .sym_strobe(strobe[1]),
        .frame_done(done[1]), .underrun(under[1]));

    bpsk_symbol_feeder #(.SYMBOL_CYCLES(2), .DIFF_ENC(1'b0)) u_sc2 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TDATA(tdata[2]),
        .S_AXIS_TVALID(tvalid[2]), .S_AXIS_TLAST(tlast[2]), .S_AXIS_TREADY(tready[2]),
        .gen_en(gen_en[2]), .phase_ctrl(phase[2]), .sym_strobe(strobe[2]),
        .frame_done(done[2]), .underrun(under[2]));

    typedef struct packed {
        logic phase;
        logic strobe;
        logic done;
        logic under;
    } cyc_exp_t;

    cyc_exp_t   exp_q[$];
    int         len_q[$];
    int         start_q[$];
    logic [7:0] fq[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   sel      = 0;
    int   run_len  = 0;
    logic model_ref;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sc_of(input int s);
        return (s == 2) ? 2 : 4;
    endfunction

    function automatic bit diff_of(input int s);
        return (s == 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d, cycle %0d): got 0x%0h, expected 0x%0h", name, sel, cyc, act, exp);
        end
    endtask

    // Reference: each bit becomes SYMBOL_CYCLES cycles of constant phase; a frame's end
    // is flagged on the last cycle of its final byte.
    task automatic model_byte(input logic [7:0] d, input bit fin, input logic l);
        int       scn;
        logic     bt;
        logic     ph;
        cyc_exp_t e;
        scn = sc_of(sel);
        for (int j = 7; j >= 0; j--) begin
            bt = d[j];
            ph = diff_of(sel) ? (model_ref ^ bt) : bt;
            model_ref = ph;
            for (int k = 0; k < scn; k++) begin
                e.phase  = ph;
                e.strobe = (k == 0);
                e.done   = fin && (j == 0) && (k == scn - 1) && l;
                e.under  = fin && (j == 0) && (k == scn - 1) && !l;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input bit first, input bit fin,
                             input int nbytes);
        logic rdy;
        int   hs_edge;
        bit   hs;
        hs = 1'b0;
        hs_edge = 0;
        tdata[sel]  = d;
        tlast[sel]  = l;
        tvalid[sel] = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            rdy = tready[sel];
            if (rdy) hs_edge = cyc + 1;
            @(posedge clk);
            #1;
            if (rdy) begin
                hs = 1'b1;
                break;
            end
        end
        tvalid[sel] = 1'b0;
        tdata[sel]  = 8'($urandom);
        tlast[sel]  = 1'($urandom);
        if (!hs) begin
            check("handshake_timeout", 32'd0, 32'd1);
            return;
        end
        check("tready_after_handshake", 32'(tready[sel]), 32'd0);
        if (first) begin
            model_ref = 1'b0;
            start_q.push_back(hs_edge + 2);
        end
        model_byte(d, fin, l);
        if (fin) len_q.push_back(8 * nbytes * sc_of(sel));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (!gen_en[sel] && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Sends fq as one frame; inner bytes carry random TLAST, which a pending reload overrides.
    task automatic send_frame(input logic tl, input int gap_max);
        int n;
        n = fq.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat ($urandom_range(gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(fq[i], (i == n - 1) ? tl : 1'($urandom), (i == 0), (i == n - 1), n);
        end
        wait_idle();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                run_len = 0;
            end else if (gen_en[sel]) begin
                if (run_len == 0) begin
                    if (start_q.size() == 0) check("unexpected_frame_start", 32'd1, 32'd0);
                    else check("start_latency", 32'(cyc), 32'(start_q.pop_front()));
                end
                run_len++;
                if (exp_q.size() == 0) check("unexpected_symbol_cycle", 32'd1, 32'd0);
                else check("symbol_cycle{phase,strobe,done,under}",
                           32'({phase[sel], strobe[sel], done[sel], under[sel]}),
                           32'(exp_q.pop_front()));
            end else begin
                check("idle_outputs{phase,strobe,done,under}",
                      32'({phase[sel], strobe[sel], done[sel], under[sel]}), 32'd0);
                if (run_len > 0) begin
                    if (len_q.size() == 0) check("unexpected_frame_end", 32'd1, 32'd0);
                    else check("frame_length", 32'(run_len), 32'(len_q.pop_front()));
                    run_len = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        tvalid = '0;
        tlast  = '0;
        for (int i = 0; i < NDUT; i++) tdata[i] = 8'h00;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gen_en", 32'(gen_en), 32'd0);
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_pulses", 32'(strobe | done | under), 32'd0);
        check("reset_tready", 32'(tready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_release", 32'(tready), 32'(3'b111));

        // Directed: single byte, back-to-back, underrun then restart.
        sel = 0;
        fq.delete(); fq.push_back(8'hA5);
        send_frame(1'b1, 0);
        fq.delete(); fq.push_back(8'hFF); fq.push_back(8'h00);
        send_frame(1'b1, 0);
        fq.delete(); fq.push_back(8'h0F);
        send_frame(1'b0, 0);
        fq.delete(); fq.push_back(8'h3C);
        send_frame(1'b1, 0);

        // Directed: differential encoding.
        sel = 1;
        fq.delete(); fq.push_back(8'hC1);
        send_frame(1'b1, 0);

        // Directed: minimum symbol length.
        sel = 2;
        fq.delete(); fq.push_back(8'h55); fq.push_back(8'hAA);
        send_frame(1'b1, 0);

        // Directed: reset in the 10th gen_en cycle of a 0xAA frame.
        sel = 0;
        send_byte(8'hAA, 1'b1, 1'b1, 1'b1, 1);
        ok = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (gen_en[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("reset_test_start_timeout", 32'd0, 32'd1);
        repeat (9) @(posedge clk);
        #1;
        check("mid_frame_phase_before_reset", 32'(phase[0]), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        len_q.delete();
        start_q.delete();
        #1;
        check("async_reset_gen_en", 32'(gen_en[0]), 32'd0);
        check("async_reset_phase", 32'(phase[0]), 32'd0);
        check("async_reset_tready", 32'(tready[0]), 32'd0);
        check("async_reset_pulses", 32'({done[0], under[0]}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_mid_reset", 32'(tready[0]), 32'd1);
        fq.delete(); fq.push_back(8'h80);
        send_frame(1'b1, 0);

        // Randomised frames on every configuration.
        for (int s = 0; s < NDUT; s++) begin
            sel = s;
            repeat (8) begin
                fq.delete();
                repeat ($urandom_range(1, 4)) fq.push_back(8'($urandom));
                send_frame(($urandom_range(0, 4) != 0), 3);
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        check("scoreboard_drained", 32'(exp_q.size() + len_q.size() + start_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
